fb_write_sched: RTL and testbench

- Write-side scheduler for the double-buffered frame RAM behind the 32x32 LED matrix scan driver.
- Shares the single RAM write port between the host pixel stream and an internal fill (clear) engine.
- Swaps back and front banks only at a scan frame boundary, so the panel never shows a half-updated frame.
- Sits between the host interface (UART/SPI decoder) and the frame RAM; the scan driver reads the bank given by disp_bank.

---
 rtl/fb_pkg.sv | 7 +
 rtl/fb_fill_counter.sv | 18 +
 rtl/fb_write_sched.sv | 102 ++++++++++
 tb/tb_fb_write_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared widths, scheduler state encoding and pixel type for the frame-buffer write path.
package fb_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_COLOR_W = 3;
    typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} sched_state_t;
    typedef logic [DEF_COLOR_W-1:0] rgb_t;
endpackage

// File: rtl/fb_fill_counter.sv
// fb_fill_counter: fill address counter, one bit wider than the address so the terminal count needs no wrap compare.
module fb_fill_counter #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            en,
    output logic [ADDR_W:0] cnt,
    output logic            done
);
    assign done = cnt[ADDR_W];
    // Address 0 is written on the start edge itself, so counting resumes at 1.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (start) cnt <= (ADDR_W+1)'(1);
        else if (en && !done) cnt <= cnt + 1'b1;
endmodule

// File: rtl/fb_write_sched.sv
// fb_write_sched: arbitrates the frame RAM write port between host pixels and the clear engine, swapping banks at frame_done.
// The clear engine exists only when FB_WRITE_SCHED_FILL_EN is defined.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [ADDR_W-1:0]  host_adr,
    input  logic [COLOR_W-1:0] host_rgb,
    input  logic               host_commit,
    input  logic               fill_start,
    input  logic [COLOR_W-1:0] fill_rgb,
    output logic               fill_busy,
    input  logic               frame_done,
    output logic               swap_pending,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_adr,
    output logic [COLOR_W-1:0] ram_din,
    output logic               ram_bank,
    output logic               disp_bank
);
    sched_state_t state;
    assign disp_bank = ~ram_bank;
`ifdef FB_WRITE_SCHED_FILL_EN
    logic [ADDR_W:0] fill_cnt;
    logic            fill_go;
    logic            fill_done;
    assign fill_go = state == IDLE && fill_start;
    assign host_ready = reset_n && state == IDLE && !fill_start;
    assign fill_busy = state == FILL;
    fb_fill_counter #(.ADDR_W(ADDR_W)) u_fill_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (fill_go),
        .en      (state == FILL),
        .cnt     (fill_cnt),
        .done    (fill_done)
    );
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_rgb};
    assign host_ready = reset_n && state == IDLE;
    assign fill_busy = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            ram_we <= 1'b0;
            ram_adr <= '0;
            ram_din <= '0;
            ram_bank <= 1'b1;
            swap_pending <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
`ifdef FB_WRITE_SCHED_FILL_EN
                    if (fill_go) begin
                        // ram_din holds the fill colour for the whole pass.
                        state <= FILL;
                        ram_we <= 1'b1;
                        ram_adr <= '0;
                        ram_din <= fill_rgb;
                        swap_pending <= host_commit;
                    end else
`endif
                    begin
                        if (host_valid) begin
                            ram_we <= 1'b1;
                            ram_adr <= host_adr;
                            ram_din <= host_rgb;
                        end
                        if (host_commit) begin
                            state <= WAIT_SWAP;
                            swap_pending <= 1'b1;
                        end
                    end
                end
`ifdef FB_WRITE_SCHED_FILL_EN
                FILL: begin
                    if (fill_done) state <= (swap_pending || host_commit) ? WAIT_SWAP : IDLE;
                    else begin
                        ram_we <= 1'b1;
                        ram_adr <= fill_cnt[ADDR_W-1:0];
                    end
                    if (host_commit) swap_pending <= 1'b1;
                end
`endif
                WAIT_SWAP: if (frame_done) begin
                    state <= IDLE;
                    ram_bank <= ~ram_bank;
                    swap_pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_fb_write_sched.sv
// tb_fb_write_sched: scoreboard bench for fb_write_sched; expected RAM writes are queued as stimulus is driven.
// Expectations follow FB_WRITE_SCHED_FILL_EN, so the same bench covers both builds.
module tb_fb_write_sched;
`ifdef FB_WRITE_SCHED_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif
    localparam int ADDR_W = 10;
    localparam int COLOR_W = 3;
    localparam int DEPTH = 1 << ADDR_W;
    typedef struct packed {
        logic               bank;
        logic [ADDR_W-1:0]  adr;
        logic [COLOR_W-1:0] din;
    } wr_t;
    logic clk = 1'b0;
    logic reset_n;
    logic host_valid, host_ready, host_commit, fill_start, fill_busy, frame_done, swap_pending;
    logic ram_we, ram_bank, disp_bank;
    logic [ADDR_W-1:0] host_adr, ram_adr;
    logic [COLOR_W-1:0] host_rgb, fill_rgb, ram_din;
    wr_t sb[$];
    logic exp_bank;
    int n_checks = 0;
    int n_err = 0;
    fb_write_sched dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_adr     (host_adr),
        .host_rgb     (host_rgb),
        .host_commit  (host_commit),
        .fill_start   (fill_start),
        .fill_rgb     (fill_rgb),
        .fill_busy    (fill_busy),
        .frame_done   (frame_done),
        .swap_pending (swap_pending),
        .ram_we       (ram_we),
        .ram_adr      (ram_adr),
        .ram_din      (ram_din),
        .ram_bank     (ram_bank),
        .disp_bank    (disp_bank)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic push_wr(input logic [ADDR_W-1:0] adr, input logic [COLOR_W-1:0] din);
        sb.push_back('{bank: exp_bank, adr: adr, din: din});
    endtask
    task automatic push_fill(input logic [COLOR_W-1:0] din);
        if (FILL_EN)
            for (int i = 0; i < DEPTH; i++) push_wr(ADDR_W'(i), din);
    endtask
    // Every RAM write the DUT issues must match the oldest queued expectation.
    always @(negedge clk)
        if (reset_n === 1'b1 && ram_we === 1'b1) begin
            if (sb.size() == 0) check("wr_unexpected_we", 32'(ram_we), 32'(0));
            else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_adr", 32'(ram_adr), 32'(e.adr));
                check("wr_din", 32'(ram_din), 32'(e.din));
                check("wr_bank", 32'(ram_bank), 32'(e.bank));
            end
        end
    initial begin
        logic [ADDR_W-1:0] adrs [3];
        logic [COLOR_W-1:0] rgbs [3];
        adrs = '{10'd5, 10'd6, 10'd7};
        rgbs = '{3'd1, 3'd2, 3'd4};
        exp_bank = 1'b1;
        reset_n = 1'b0;
        {host_valid, host_commit, fill_start, frame_done} = '0;
        host_adr = '0;
        host_rgb = '0;
        fill_rgb = '0;
        #7;
        check("rst_we", 32'(ram_we), 32'(0));
        check("rst_adr", 32'(ram_adr), 32'(0));
        check("rst_din", 32'(ram_din), 32'(0));
        check("rst_bank", 32'(ram_bank), 32'(1));
        check("rst_disp", 32'(disp_bank), 32'(0));
        check("rst_busy", 32'(fill_busy), 32'(0));
        check("rst_pend", 32'(swap_pending), 32'(0));
        check("rst_ready", 32'(host_ready), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        step();
        // Back-to-back host writes
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_adr = adrs[i];
            host_rgb = rgbs[i];
            check("t1_ready", 32'(host_ready), 32'(1));
            push_wr(adrs[i], rgbs[i]);
            step();
        end
        host_valid = 1'b0;
        step();
        check("t1_idle_we", 32'(ram_we), 32'(0));
        // Fill with a competing host write: fill wins when the engine exists
        fill_start = 1'b1;
        fill_rgb = 3'd3;
        host_valid = 1'b1;
        host_adr = 10'd9;
        host_rgb = 3'd5;
        check("t2_ready_at_start", 32'(host_ready), 32'(!FILL_EN));
        if (FILL_EN) push_fill(3'd3);
        else push_wr(10'd9, 3'd5);
        step();
        {fill_start, host_valid} = '0;
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_busy", 32'(fill_busy), 32'(FILL_EN));
            check("t2_ready", 32'(host_ready), 32'(!FILL_EN));
            step();
        end
        check("t2_busy_end", 32'(fill_busy), 32'(0));
        check("t2_ready_end", 32'(host_ready), 32'(1));
        check("t2_sb_drained", 32'(sb.size()), 32'(0));
        // Commit, swap 10 cycles later; stray frame_done in IDLE first
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("t3_idle_fd_bank", 32'(ram_bank), 32'(1));
        host_commit = 1'b1;
        step();
        host_commit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t3_pend", 32'(swap_pending), 32'(1));
            check("t3_hold_bank", 32'(ram_bank), 32'(1));
            check("t3_ready_low", 32'(host_ready), 32'(0));
            step();
        end
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        exp_bank = 1'b0;
        check("t3_pend_clr", 32'(swap_pending), 32'(0));
        check("t3_bank", 32'(ram_bank), 32'(0));
        check("t3_disp", 32'(disp_bank), 32'(1));
        check("t3_ready", 32'(host_ready), 32'(1));
        host_valid = 1'b1;
        host_adr = 10'd1023;
        host_rgb = 3'd7;
        push_wr(10'd1023, 3'd7);
        step();
        host_valid = 1'b0;
        // Commit together with frame_done: swap must wait for the next pulse
        host_commit = 1'b1;
        frame_done = 1'b1;
        step();
        {host_commit, frame_done} = '0;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_commit = (i == 1);
            host_adr = 10'd44;
            host_rgb = 3'd6;
            check("t4_pend", 32'(swap_pending), 32'(1));
            check("t4_hold_bank", 32'(ram_bank), 32'(0));
            step();
        end
        {host_valid, host_commit} = '0;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        exp_bank = 1'b1;
        check("t4_bank", 32'(ram_bank), 32'(1));
        check("t4_disp", 32'(disp_bank), 32'(0));
        check("t4_pend_clr", 32'(swap_pending), 32'(0));
        check("t4_ready", 32'(host_ready), 32'(1));
        // Commit at fill cycle 100
        fill_start = 1'b1;
        fill_rgb = 3'd2;
        push_fill(3'd2);
        step();
        fill_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            host_commit = (i == 100);
            check("t5_busy", 32'(fill_busy), 32'(FILL_EN));
            step();
            if (i >= 100) check("t5_pend", 32'(swap_pending), 32'(1));
        end
        host_commit = 1'b0;
        check("t5_busy_end", 32'(fill_busy), 32'(0));
        check("t5_pend_end", 32'(swap_pending), 32'(1));
        check("t5_ready_low", 32'(host_ready), 32'(0));
        check("t5_hold_bank", 32'(ram_bank), 32'(1));
        check("t5_sb_drained", 32'(sb.size()), 32'(0));
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        exp_bank = 1'b0;
        check("t5_bank", 32'(ram_bank), 32'(0));
        check("t5_pend_clr", 32'(swap_pending), 32'(0));
        // Asynchronous reset at fill cycle 500
        fill_start = 1'b1;
        fill_rgb = 3'd5;
        push_fill(3'd5);
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 500; i++) step();
        check("t6_we_before", 32'(ram_we), 32'(FILL_EN));
        #2;
        reset_n = 1'b0;
        sb.delete();
        exp_bank = 1'b1;
        #1;
        check("t6_we", 32'(ram_we), 32'(0));
        check("t6_bank", 32'(ram_bank), 32'(1));
        check("t6_disp", 32'(disp_bank), 32'(0));
        check("t6_busy", 32'(fill_busy), 32'(0));
        check("t6_pend", 32'(swap_pending), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        step();
        host_valid = 1'b1;
        host_adr = 10'd300;
        host_rgb = 3'd1;
        check("t6_ready", 32'(host_ready), 32'(1));
        push_wr(10'd300, 3'd1);
        step();
        host_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
